// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module : mem_arbiter_pkg
// Brief  : Shared state/command encodings and sizing helper for mem_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } arb_state_t;

    // Command encodings match the memory model's rw pin.
    localparam logic c_mem_read  = 1'b0;
    localparam logic c_mem_write = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_rr_pick.sv
// ============================================================================
// Module : mem_arbiter_rr_pick
// Brief  : Combinational round-robin picker: first requester at or after ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter_rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int w_cand;

    // Scan from the farthest offset down so the closest match to ptr wins.
    always_comb begin
        idx    = '0;
        any    = 1'b0;
        grant  = '0;
        w_cand = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = (int'(ptr) + k) % NREQ;
            if (req[w_cand]) begin
                idx = IDX_W'(w_cand);
                any = 1'b1;
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Brief  : Round-robin arbiter sharing one memory port among NREQ requesters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_rw,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   mem_valid,
    output logic                   mem_rw,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   busy
);

    localparam int IDX_W = idx_width(NREQ);
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_gnt_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;

    logic [NREQ-1:0]   w_pick_grant;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_pick_any;
    logic              w_issue;
    logic [IDX_W-1:0]  w_ptr_nxt;

    mem_arbiter_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_pick_grant),
        .idx   (w_pick_idx),
        .any   (w_pick_any)
    );

    assign w_ptr_nxt = (w_pick_idx == IDX_W'(NREQ - 1)) ? '0 : w_pick_idx + IDX_W'(1);

    // Grants are gated by rst_n so nothing is issued while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        req_ready   = '0;
        mem_valid   = 1'b0;
        mem_rw      = c_mem_read;
        mem_addr    = '0;
        mem_wdata   = '0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any && rst_n) begin
                    w_issue   = 1'b1;
                    req_ready = w_pick_grant;
                    mem_valid = 1'b1;
                    mem_rw    = req_rw[w_pick_idx];
                    mem_addr  = req_addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
                    mem_wdata = req_wdata[int'(w_pick_idx)*DATA_W +: DATA_W];
                    if (req_rw[w_pick_idx] == c_mem_read) begin
                        w_state_nxt = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_gnt_idx   <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (w_issue) begin
                r_rr_ptr  <= w_ptr_nxt;
                r_gnt_idx <= w_pick_idx;
                r_cnt     <= CNT_W'(RD_LAT - 1);
            end
            if (r_state == ST_RD_WAIT) begin
                if (r_cnt == '0) begin
                    r_rsp_valid[r_gnt_idx] <= 1'b1;
                    r_rsp_rdata            <= mem_rdata;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module : tb_mem_arbiter
// Brief  : Self-checking bench for mem_arbiter with a behavioural memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int RD_LAT = 1;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid, req_rw, req_ready, rsp_valid;
    logic [31:0] req_addr, req_wdata;
    logic [15:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_valid, mem_rw, busy;

    logic [2:0]  v3, rdy3, rsp3;
    logic [47:0] addr3, wd3;
    logic [15:0] rdata3, maddr3, mwd3;
    logic        mv3, mrw3, busy3;

    mem_arbiter #(.NREQ(2), .ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.NREQ(3), .ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v3), .req_rw(3'b111), .req_addr(addr3), .req_wdata(wd3),
        .req_ready(rdy3), .rsp_valid(rsp3), .rsp_rdata(rdata3),
        .mem_valid(mv3), .mem_rw(mrw3), .mem_addr(maddr3), .mem_wdata(mwd3),
        .mem_rdata(16'h0000), .busy(busy3)
    );

    // Memory seen by the DUT, and an independent copy kept by the reference model.
    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    always @(posedge clk) begin
        if (mem_valid) begin
            if (mem_rw) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int ncheck = 0;
    int npass  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncheck++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Reference model state: requester-visible view of the arbiter.
    int          m_ptr, m_wait, m_owner;
    logic [15:0] m_rd, m_last, m_next_data;
    logic [1:0]  m_next_rsp;
    logic [1:0]  acc;

    logic        t_v  [2];
    logic        t_rw [2];
    logic [15:0] t_a  [2];
    logic [15:0] t_d  [2];

    function automatic int pick(input logic [3:0] v, input int ptr, input int n);
        for (int k = 0; k < n; k++) begin
            if (v[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_wait = 0; m_owner = 0;
        m_rd = '0; m_last = '0; m_next_data = '0; m_next_rsp = '0;
    endtask

    task automatic step();
        int          g;
        logic [1:0]  e_ready, cur_rsp;
        logic        e_mv, e_busy, e_rw;
        logic [15:0] e_addr, e_wd;
        @(negedge clk);
        req_valid = {t_v[1], t_v[0]};
        req_rw    = {t_rw[1], t_rw[0]};
        req_addr  = {t_a[1], t_a[0]};
        req_wdata = {t_d[1], t_d[0]};
        #1;
        cur_rsp = m_next_rsp;
        if (cur_rsp != 0) m_last = m_next_data;
        m_next_rsp = '0;
        e_ready = '0; e_mv = 0; e_busy = 0; e_rw = 0; e_addr = '0; e_wd = '0;
        if (m_wait > 0) begin
            e_busy = 1;
            m_wait--;
            if (m_wait == 0) begin
                m_next_rsp = 2'(1 << m_owner);
                m_next_data = m_rd;
            end
        end else begin
            g = pick({2'b00, req_valid}, m_ptr, 2);
            if (g >= 0) begin
                e_ready = 2'(1 << g);
                e_mv = 1; e_rw = t_rw[g]; e_addr = t_a[g]; e_wd = t_d[g];
                m_ptr = (g + 1) % 2;
                if (t_rw[g]) ref_mem[t_a[g]] = t_d[g];
                else begin
                    m_wait = RD_LAT; m_owner = g; m_rd = ref_mem[t_a[g]];
                end
            end
        end
        acc = e_ready;
        check("req_ready", 32'(req_ready), 32'(e_ready));
        check("mem_valid", 32'(mem_valid), 32'(e_mv));
        check("busy",      32'(busy),      32'(e_busy));
        check("mem_rw",    32'(mem_rw),    32'(e_rw));
        check("mem_addr",  32'(mem_addr),  32'(e_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(e_wd));
        check("rsp_valid", 32'(rsp_valid), 32'(cur_rsp));
        check("rsp_rdata", 32'(rsp_rdata), 32'(m_last));
    endtask

    task automatic set_req(input int i, input logic v, input logic rw,
                           input logic [15:0] a, input logic [15:0] d);
        t_v[i] = v; t_rw[i] = rw; t_a[i] = a; t_d[i] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 2'b11;
        v3 = 3'b111;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_mem_valid", 32'(mem_valid), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_ready3",    32'(rdy3),      32'h0);
        repeat (2) @(posedge clk);
        #2;
        v3 = 3'b000;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step3(input logic [2:0] v, input logic [2:0] exp);
        @(negedge clk);
        v3 = v;
        #1;
        check("nreq3_ready", 32'(rdy3), 32'(exp));
        check("nreq3_mem_valid", 32'(mv3), 32'(exp != 0));
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        v3 = '0;
        addr3 = {16'h0302, 16'h0301, 16'h0300};
        wd3   = {16'h2222, 16'h1111, 16'h0000};
        mem_rdata = '0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i) ^ 16'h5A5A;
            ref_mem[i] = 16'(i) ^ 16'h5A5A;
        end
        for (int i = 0; i < 2; i++) set_req(i, 0, 0, '0, '0);
        model_reset();

        do_reset();

        // First grant after release goes to requester 0.
        set_req(0, 1, 1, 16'h0000, 16'h1234);
        set_req(1, 1, 1, 16'h0004, 16'h5678);
        step();

        // NREQ=3 rotation and wrap; lone req2 after ptr wraps to 0.
        step3(3'b111, 3'b001);
        step3(3'b111, 3'b010);
        step3(3'b111, 3'b100);
        step3(3'b100, 3'b100);
        step3(3'b111, 3'b001);
        step3(3'b000, 3'b000);
        v3 = 3'b000;

        // Single write then read at 0x0010.
        set_req(1, 0, 0, '0, '0);
        set_req(0, 1, 1, 16'h0010, 16'hBEEF);
        step();
        set_req(0, 1, 0, 16'h0010, 16'h0000);
        step();
        set_req(0, 0, 0, '0, '0);
        step();
        step();
        check("beef_readback", 32'(rsp_rdata), 32'h0000BEEF);

        // Contention: both hold reads.
        set_req(0, 1, 0, 16'h0001, 16'h0);
        set_req(1, 1, 0, 16'h0002, 16'h0);
        repeat (8) step();

        // Back-to-back writes from both requesters.
        for (int k = 0; k < 8; k++) begin
            set_req(0, 1, 1, 16'(16'h0020 + 2 * k), 16'($urandom));
            set_req(1, 1, 1, 16'(16'h0021 + 2 * k), 16'($urandom));
            step();
        end
        set_req(1, 0, 0, '0, '0);
        for (int k = 0; k < 8; k++) begin
            set_req(0, 1, 0, 16'(16'h0020 + k), 16'h0);
            step();
            set_req(0, 0, 0, '0, '0);
            step();
        end
        step();

        // Reset while a read is outstanding: the response must never appear.
        set_req(0, 1, 0, 16'h0003, 16'h0);
        step();
        set_req(0, 0, 0, '0, '0);
        do_reset();
        set_req(1, 1, 1, 16'h0007, 16'hCAFE);
        step();
        set_req(1, 0, 0, '0, '0);
        repeat (3) step();

        // Randomized traffic; requesters hold fields until accepted.
        acc = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (t_v[i] && !acc[i]) begin
                    if ($urandom_range(7) == 0) t_v[i] = 1'b0;
                end else begin
                    t_v[i]  = ($urandom_range(3) != 0);
                    t_rw[i] = 1'($urandom_range(1));
                    t_a[i]  = 16'($urandom_range(15));
                    t_d[i]  = 16'($urandom);
                end
            end
            step();
        end

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule

`default_nettype wire
